// File: rtl/guess_scorer_1a2b.sv
// guess_scorer_1a2b: assembles classifier digits into a DIGITS-long guess and
// scores it against a loaded secret with 1A2B rules, one position per cycle.
// It also tracks turns and reports win or lose.
// Optional feature macro: DUP_REJECT_EN. When it is defined, a digit that
// duplicates an already captured position is rejected and err_dup pulses.
module guess_scorer_1a2b #(
  parameter int DIGITS     = 4,
  parameter int DIGIT_BITS = 4,
  parameter int MAX_TURNS  = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DIGIT_BITS-1:0]        digit_in,
  input  logic                         digit_valid,
  input  logic                         secret_load,
  input  logic [DIGITS*DIGIT_BITS-1:0] secret_in,
  input  logic                         guess_clear,
  output logic [DIGITS*DIGIT_BITS-1:0] guess_digits,
  output logic [3:0]                   guess_count,
  output logic [3:0]                   score_a,
  output logic [3:0]                   score_b,
  output logic                         score_valid,
  output logic                         busy,
  output logic [3:0]                   turns,
  output logic                         win,
  output logic                         lose,
  output logic                         err_range,
  output logic                         err_dup,
  output logic                         err_secret
);

  localparam int GW = DIGITS * DIGIT_BITS;
  localparam logic [3:0] DIG4  = 4'(DIGITS);
  localparam logic [3:0] MAX4  = 4'(MAX_TURNS);
  localparam logic [DIGIT_BITS-1:0] MAX_DIGIT = DIGIT_BITS'(9);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SCORE,
    S_WIN,
    S_LOSE
  } state_t;

  state_t state, state_d;

  logic          dv_prev;
  logic          dv_rise;
  logic [GW-1:0] secret;
  logic [3:0]    idx;
  logic [3:0]    acc_a, acc_b;
  logic [GW-1:0] guess_cap;
  logic [DIGIT_BITS-1:0] g_cur, s_cur;
  logic          a_hit, b_hit, in_secret;
  logic          secret_ok;
  logic [3:0]    turns_inc;

  logic load_go, load_bad, clr_go, cap_go, rng_go, step_go, done_go;
`ifdef DUP_REJECT_EN
  logic dup_go;
  logic dup_hit;
`endif

  // Position 0 lives in the most significant nibble.
  function automatic logic [DIGIT_BITS-1:0] nib_of(input logic [GW-1:0] v,
                                                   input int unsigned p);
    return v[(DIGITS-1-p)*DIGIT_BITS +: DIGIT_BITS];
  endfunction

  assign dv_rise   = digit_valid & ~dv_prev;
  assign busy      = (state == S_SCORE);
  assign turns_inc = (turns == 4'hF) ? turns : turns + 4'd1;

  // Secret validation: every digit 0..9 and all digits pairwise distinct.
  always_comb begin
    secret_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (nib_of(secret_in, i) > MAX_DIGIT) secret_ok = 1'b0;
      for (int unsigned j = i + 1; j < DIGITS; j++) begin
        if (nib_of(secret_in, i) == nib_of(secret_in, j)) secret_ok = 1'b0;
      end
    end
  end

  // Guess image with digit_in written at the next free position.
  always_comb begin
    guess_cap = guess_digits;
    for (int unsigned p = 0; p < DIGITS; p++) begin
      if (4'(p) == guess_count)
        guess_cap[(DIGITS-1-p)*DIGIT_BITS +: DIGIT_BITS] = digit_in;
    end
  end

`ifdef DUP_REJECT_EN
  // Duplicate detection against positions already captured.
  always_comb begin
    dup_hit = 1'b0;
    for (int unsigned p = 0; p < DIGITS; p++) begin
      if (4'(p) < guess_count && nib_of(guess_digits, p) == digit_in)
        dup_hit = 1'b1;
    end
  end
`endif

  // Per-position A/B evaluation for the scorer index.
  always_comb begin
    g_cur     = '0;
    s_cur     = '0;
    in_secret = 1'b0;
    for (int unsigned p = 0; p < DIGITS; p++) begin
      if (4'(p) == idx) begin
        g_cur = nib_of(guess_digits, p);
        s_cur = nib_of(secret, p);
      end
    end
    for (int unsigned p = 0; p < DIGITS; p++) begin
      if (nib_of(secret, p) == g_cur) in_secret = 1'b1;
    end
    a_hit = (g_cur == s_cur);
    b_hit = ~a_hit & in_secret;
  end

  // Next-state and control strobes; secret_load outranks everything.
  always_comb begin
    state_d  = state;
    load_go  = secret_load & secret_ok;
    load_bad = secret_load & ~secret_ok;
    clr_go   = 1'b0;
    cap_go   = 1'b0;
    rng_go   = 1'b0;
    step_go  = 1'b0;
    done_go  = 1'b0;
`ifdef DUP_REJECT_EN
    dup_go   = 1'b0;
`endif
    if (load_go) begin
      state_d = S_COLLECT;
    end else if (!load_bad) begin
      unique case (state)
        S_COLLECT: begin
          if (guess_clear) begin
            clr_go = 1'b1;
          end else if (dv_rise) begin
            if (digit_in > MAX_DIGIT) begin
              rng_go = 1'b1;
`ifdef DUP_REJECT_EN
            end else if (dup_hit) begin
              dup_go = 1'b1;
`endif
            end else begin
              cap_go = 1'b1;
              if (guess_count == DIG4 - 4'd1) state_d = S_SCORE;
            end
          end
        end
        S_SCORE: begin
          // idx == DIGITS is the extra finalize cycle after the last position.
          if (idx == DIG4) begin
            done_go = 1'b1;
            if (acc_a == DIG4)          state_d = S_WIN;
            else if (turns_inc == MAX4) state_d = S_LOSE;
            else                        state_d = S_COLLECT;
          end else begin
            step_go = 1'b1;
          end
        end
        default: state_d = state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Datapath: capture, scoring accumulators, results and error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dv_prev      <= 1'b0;
      secret       <= '0;
      guess_digits <= '0;
      guess_count  <= '0;
      idx          <= '0;
      acc_a        <= '0;
      acc_b        <= '0;
      score_a      <= '0;
      score_b      <= '0;
      score_valid  <= 1'b0;
      turns        <= '0;
      win          <= 1'b0;
      lose         <= 1'b0;
      err_range    <= 1'b0;
      err_secret   <= 1'b0;
    end else begin
      dv_prev     <= digit_valid;
      score_valid <= 1'b0;
      err_range   <= rng_go;
      err_secret  <= load_bad;
      if (load_go) begin
        secret       <= secret_in;
        guess_digits <= '0;
        guess_count  <= '0;
        idx          <= '0;
        acc_a        <= '0;
        acc_b        <= '0;
        score_a      <= '0;
        score_b      <= '0;
        turns        <= '0;
        win          <= 1'b0;
        lose         <= 1'b0;
      end
      if (clr_go) begin
        guess_digits <= '0;
        guess_count  <= '0;
      end
      if (cap_go) begin
        guess_digits <= guess_cap;
        guess_count  <= guess_count + 4'd1;
        idx          <= '0;
        acc_a        <= '0;
        acc_b        <= '0;
      end
      if (step_go) begin
        acc_a <= acc_a + {3'b000, a_hit};
        acc_b <= acc_b + {3'b000, b_hit};
        idx   <= idx + 4'd1;
      end
      if (done_go) begin
        score_a     <= acc_a;
        score_b     <= acc_b;
        score_valid <= 1'b1;
        turns       <= turns_inc;
        guess_count <= '0;
        win         <= (state_d == S_WIN);
        lose        <= (state_d == S_LOSE);
      end
    end
  end

`ifdef DUP_REJECT_EN
  // Duplicate-rejection pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) err_dup <= 1'b0;
    else        err_dup <= dup_go;
  end
`else
  assign err_dup = 1'b0;
`endif

endmodule

// File: tb/tb_guess_scorer_1a2b.sv
// Self-checking bench for guess_scorer_1a2b (DIGITS=4, MAX_TURNS=10).
module tb_guess_scorer_1a2b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  digit_in;
  logic        digit_valid;
  logic        secret_load;
  logic [15:0] secret_in;
  logic        guess_clear;
  logic [15:0] guess_digits;
  logic [3:0]  guess_count, score_a, score_b, turns;
  logic        score_valid, busy, win, lose, err_range, err_dup, err_secret;

  int errors = 0;
  int checks = 0;

  logic [15:0] cur_secret;
  int exp_turns;
  logic exp_win, exp_lose;
  logic last_rng, last_dup;

  guess_scorer_1a2b #(.DIGITS(4), .DIGIT_BITS(4), .MAX_TURNS(10)) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
    .secret_load(secret_load), .secret_in(secret_in), .guess_clear(guess_clear),
    .guess_digits(guess_digits), .guess_count(guess_count), .score_a(score_a),
    .score_b(score_b), .score_valid(score_valid), .busy(busy), .turns(turns),
    .win(win), .lose(lose), .err_range(err_range), .err_dup(err_dup),
    .err_secret(err_secret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int p);
    return v[(3-p)*4 +: 4];
  endfunction

  // Reference scoring from the game rules.
  function automatic void model_score(input logic [15:0] s, input logic [15:0] g,
                                      output int a, output int b);
    a = 0; b = 0;
    for (int i = 0; i < 4; i++) begin
      if (nib(g, i) == nib(s, i)) a++;
      else begin
        bit found = 0;
        for (int j = 0; j < 4; j++) if (nib(s, j) == nib(g, i)) found = 1;
        if (found) b++;
      end
    end
  endfunction

  function automatic logic [15:0] rand_distinct();
    int d[10];
    logic [15:0] r;
    for (int i = 0; i < 10; i++) d[i] = i;
    for (int i = 9; i > 0; i--) begin
      int k = $urandom_range(i, 0);
      int t = d[i];
      d[i] = d[k]; d[k] = t;
    end
    r = {d[0][3:0], d[1][3:0], d[2][3:0], d[3][3:0]};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic strobe(input logic [3:0] d);
    digit_in = d; digit_valid = 1'b1;
    @(posedge clk); #1;
    last_rng = err_range; last_dup = err_dup;
    digit_valid = 1'b0;
    tick();
  endtask

  task automatic load(input logic [15:0] s);
    secret_in = s; secret_load = 1'b1;
    tick();
    secret_load = 1'b0;
    cur_secret = s; exp_turns = 0; exp_win = 0; exp_lose = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_guess"}, guess_digits, 0);
    chk({tag, "_count"}, guess_count, 0);
    chk({tag, "_sa"}, score_a, 0);
    chk({tag, "_sb"}, score_b, 0);
    chk({tag, "_flags"}, {score_valid, busy, win, lose, err_range, err_dup, err_secret}, 0);
    chk({tag, "_turns"}, turns, 0);
  endtask

  // Enters one full guess, measures score latency and checks the result.
  task automatic play(input string tag, input logic [15:0] g);
    int n, a, b;
    bit seen;
    for (int p = 0; p < 3; p++) strobe(nib(g, p));
    digit_in = nib(g, 3); digit_valid = 1'b1;
    @(posedge clk); #1;
    digit_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    n = 0; seen = 0;
    while (n < 20 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (score_valid) seen = 1;
    end
    chk({tag, "_latency"}, n, 5);
    model_score(cur_secret, g, a, b);
    exp_turns = (exp_turns == 15) ? 15 : exp_turns + 1;
    exp_win  = (a == 4);
    exp_lose = !exp_win && (exp_turns == 10);
    chk({tag, "_a"}, score_a, a);
    chk({tag, "_b"}, score_b, b);
    chk({tag, "_turns"}, turns, exp_turns);
    chk({tag, "_winlose"}, {win, lose}, {exp_win, exp_lose});
    chk({tag, "_guess"}, guess_digits, g);
    chk({tag, "_count"}, guess_count, 0);
    chk({tag, "_busy_after"}, busy, 0);
    tick();
    chk({tag, "_sv_pulse"}, score_valid, 0);
  endtask

  initial begin
    int n;
    bit seen;
    logic [15:0] g;
    rst_n = 1'b0; digit_in = '0; digit_valid = 1'b0; secret_load = 1'b0;
    secret_in = '0; guess_clear = 1'b0; cur_secret = '0;
    exp_turns = 0; exp_win = 0; exp_lose = 0; last_rng = 0; last_dup = 0;
    tick(); tick();
    rst_n = 1'b1;
    check_zero("reset");

    // IDLE ignores digits.
    digit_in = 4'd3; digit_valid = 1'b1;
    repeat (5) tick();
    digit_valid = 1'b0;
    tick();
    check_zero("idle");

    // Secret 1234, guess 1243 -> 2A2B.
    load(16'h1234);
    chk("load_err", err_secret, 0);
    play("g1243", 16'h1243);
    chk("g1243_a_const", score_a, 2);
    chk("g1243_b_const", score_b, 2);

    play("g5678", 16'h5678);
    strobe(4'hE);
    chk("range_pulse", last_rng, 1);
    chk("range_count", guess_count, 0);
    chk("range_guess", guess_digits, 16'h5678);

    // Held level captures exactly once.
    digit_in = 4'd9; digit_valid = 1'b1;
    repeat (4) tick();
    digit_valid = 1'b0;
    tick();
    chk("level_count", guess_count, 1);
    chk("level_guess", guess_digits, 16'h9678);

    // Clear beats a same-cycle rise.
    digit_in = 4'd7; digit_valid = 1'b1; guess_clear = 1'b1;
    tick();
    guess_clear = 1'b0; digit_valid = 1'b0;
    chk("clear_count", guess_count, 0);
    chk("clear_guess", guess_digits, 0);
    tick();

    play("win", 16'h1234);
    strobe(4'd5);
    chk("win_ignore_count", guess_count, 0);
    chk("win_ignore_guess", guess_digits, 16'h1234);
    chk("win_hold", {win, lose, busy}, 3'b100);

    // Duplicate digits.
    load(16'h1234);
    chk("reload_turns", turns, 0);
    chk("reload_win", win, 0);
`ifdef DUP_REJECT_EN
    strobe(4'd1);
    strobe(4'd1);
    chk("dup_pulse", last_dup, 1);
    chk("dup_count", guess_count, 1);
    guess_clear = 1'b1; tick(); guess_clear = 1'b0;
`else
    play("dup", 16'h1124);
    chk("dup_a_const", score_a, 2);
    chk("dup_b_const", score_b, 2);
    chk("dup_flag", err_dup, 0);
`endif

    // Rejected secret leaves everything unchanged.
    strobe(4'd9);
    n = guess_count;
    secret_in = 16'h1123; secret_load = 1'b1;
    tick();
    secret_load = 1'b0;
    chk("bad_secret_pulse", err_secret, 1);
    chk("bad_secret_count", guess_count, n);
    chk("bad_secret_turns", turns, exp_turns);
    tick();
    chk("bad_secret_pulse_end", err_secret, 0);
    guess_clear = 1'b1; tick(); guess_clear = 1'b0;

    // Lose after MAX_TURNS misses.
    load(16'h1234);
    for (int t = 0; t < 10; t++) play($sformatf("lose%0d", t), 16'h5678);
    chk("lose_flag", lose, 1);
    chk("lose_turns", turns, 10);
    strobe(4'd1);
    chk("lose_ignore", guess_count, 0);
    load(16'h9876);
    chk("newgame_turns", turns, 0);
    chk("newgame_lose", lose, 0);
    strobe(4'd1);
    chk("newgame_collect", guess_count, 1);
    guess_clear = 1'b1; tick(); guess_clear = 1'b0;

    // Randomized games against the reference model.
    for (int gm = 0; gm < 4; gm++) begin
      load(rand_distinct());
      for (int t = 0; t < 10 && !exp_win && !exp_lose; t++) begin
        g = ($urandom_range(4, 0) == 0) ? cur_secret : rand_distinct();
        play($sformatf("rnd%0d_%0d", gm, t), g);
      end
    end

    // Reset in the middle of scoring.
    load(16'h4321);
    for (int p = 0; p < 3; p++) strobe(4'(p + 5));
    digit_in = 4'd8; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_zero("rst_score");
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (score_valid) seen = 1;
    end
    chk("rst_no_sv", seen, 0);
    strobe(4'd2);
    chk("rst_idle_count", guess_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
